// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss-handling sequencer for the 4-way, 4 KB data cache.
//
// Accepts one load/store at a time from the LSU. It looks the request up in the
// cache, fetches the missing word from memory on a miss, writes a dirty victim
// back, and then replays the lookup. It also keeps saturating hit/miss counters.
//
// Ports
//   CLK_cpu, RST_cpu_n            clock; synchronous active-low reset
//   req_*                         LSU request (valid/we/addr/wdata/size), req_ready
//   resp_valid/err/rdata          one-cycle completion pulse to the LSU
//   dc_read_en/write_en/fetch     cache commands (at most one high at a time)
//   dc_read_addr/write_addr       cache addresses
//   dc_write_data/store_size      cache write data and size
//   dc_cache_miss/rdata/tag       cache lookup result and victim information
//   mem_req/we/addr/wdata         memory request, held until mem_ack
//   mem_ack/rdata                 memory acknowledge and fill data
//   stat_hits, stat_misses        saturating statistics counters
module dcache_ctrl #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              CLK_cpu,
  input  logic              RST_cpu_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [19:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              dc_read_en,
  output logic              dc_write_en,
  output logic              dc_fetch,
  output logic [19:0]       dc_read_addr,
  output logic [19:0]       dc_write_addr,
  output logic [31:0]       dc_write_data,
  output logic [1:0]        dc_store_size,
  input  logic              dc_cache_miss,
  input  logic [31:0]       dc_rdata,
  input  logic [15:0]       dc_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [19:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses
);

  typedef enum logic [3:0] {
    StIdle, StChk, StLk1, StLk2, StMrd, StFl1, StFl2, StWb, StRsp
  } state_e;

  state_e              state_q, state_d;
  logic [19:0]         addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                replay_q, replay_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         fill_q, fill_d;
  logic [9:0]          vtag_q, vtag_d;
  logic [31:0]         vdata_q, vdata_d;
  logic [STAT_W-1:0]   hits_q, hits_d;
  logic [STAT_W-1:0]   misses_q, misses_d;
  logic                misaligned;

  // Only the valid, dirty and tag fields of dc_tag carry meaning.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{dc_tag[15:14], dc_tag[11:10]};

  assign misaligned = (size_q == 2'b11) ||
                      (size_q == 2'b01 && addr_q[0]) ||
                      (size_q == 2'b10 && addr_q[1:0] != 2'b00);

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  always_ff @(posedge CLK_cpu) begin
    if (!RST_cpu_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      size_q   <= '0;
      replay_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      fill_q   <= '0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      replay_q <= replay_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      fill_q   <= fill_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    replay_d = replay_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    fill_d   = fill_q;
    vtag_d   = vtag_q;
    vdata_d  = vdata_q;
    hits_d   = hits_q;
    misses_d = misses_q;

    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    dc_read_en    = 1'b0;
    dc_write_en   = 1'b0;
    dc_fetch      = 1'b0;
    dc_read_addr  = '0;
    dc_write_addr = '0;
    dc_write_data = '0;
    dc_store_size = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d   = req_addr;
          we_d     = req_we;
          wdata_d  = req_wdata;
          size_d   = req_size;
          err_d    = 1'b0;
          rdata_d  = '0;
          replay_d = 1'b0;
          state_d  = StChk;
        end
      end

      StChk: begin
        if (misaligned) begin
          err_d   = 1'b1;
          state_d = StRsp;
        end else begin
          replay_d = 1'b0;
          state_d  = StLk1;
        end
      end

      StLk1, StLk2: begin
        if (we_q) begin
          dc_write_en   = 1'b1;
          dc_write_addr = addr_q;
          dc_write_data = wdata_q;
          dc_store_size = size_q;
        end else begin
          dc_read_en   = 1'b1;
          dc_read_addr = addr_q;
        end
        if (state_q == StLk1) begin
          state_d = StLk2;
        end else if (!dc_cache_miss) begin
          if (!we_q) rdata_d = dc_rdata;
          // Replayed lookups already counted as a miss.
          if (!replay_q && hits_q != '1) hits_d = hits_q + STAT_W'(1);
          state_d = StRsp;
        end else if (!replay_q) begin
          if (misses_q != '1) misses_d = misses_q + STAT_W'(1);
          state_d = StMrd;
        end else begin
          err_d   = 1'b1;
          state_d = StRsp;
        end
      end

      StMrd: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[19:2], 2'b00};
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = StFl1;
        end
      end

      StFl1, StFl2: begin
        dc_fetch      = 1'b1;
        dc_write_addr = addr_q;
        dc_write_data = fill_q;
        if (state_q == StFl1) begin
          state_d = StFl2;
        end else begin
          vtag_d  = dc_tag[9:0];
          vdata_d = dc_rdata;
          if (dc_tag[13] && dc_tag[12]) begin
            state_d = StWb;
          end else begin
            replay_d = 1'b1;
            state_d  = StLk1;
          end
        end
      end

      StWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, addr_q[9:2], 2'b00};
        mem_wdata = vdata_q;
        if (mem_ack) begin
          replay_d = 1'b1;
          state_d  = StLk1;
        end
      end

      StRsp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'h0 : rdata_q;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl.
// A tiny cache model (present/data/victim) and a memory responder inside run_req
// answer the DUT's commands; each test task checks its own expected values.
module tb_dcache_ctrl;

  localparam int unsigned STAT_W = 16;

  logic              CLK_cpu;
  logic              RST_cpu_n;
  logic              req_valid;
  logic              req_we;
  logic [19:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              dc_read_en;
  logic              dc_write_en;
  logic              dc_fetch;
  logic [19:0]       dc_read_addr;
  logic [19:0]       dc_write_addr;
  logic [31:0]       dc_write_data;
  logic [1:0]        dc_store_size;
  logic              dc_cache_miss;
  logic [31:0]       dc_rdata;
  logic [15:0]       dc_tag;
  logic              mem_req;
  logic              mem_we;
  logic [19:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_misses;

  // Cache model
  logic        model_present;
  logic [31:0] model_data;
  logic        always_miss;
  logic [15:0] vic_tag;
  logic [31:0] vic_data;

  assign dc_cache_miss = always_miss | ~model_present;
  assign dc_rdata      = dc_fetch ? vic_data : model_data;
  assign dc_tag        = dc_fetch ? vic_tag : 16'h0;

  int checks;
  int errors;

  // Observations from the last run_req
  int          r_lat;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        saw_mem, saw_read_en, saw_write_en, saw_fetch;
  logic        onehot_bad, ack_hold_bad, wb_seen;
  logic [19:0] r_lk_addr, r_rd_addr, r_wb_addr;
  logic [31:0] r_st_data, r_fetch_data, r_wb_data;
  logic [1:0]  r_store_size;

  dcache_ctrl #(.STAT_W(STAT_W)) dut (
    .CLK_cpu       (CLK_cpu),
    .RST_cpu_n     (RST_cpu_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .dc_read_en    (dc_read_en),
    .dc_write_en   (dc_write_en),
    .dc_fetch      (dc_fetch),
    .dc_read_addr  (dc_read_addr),
    .dc_write_addr (dc_write_addr),
    .dc_write_data (dc_write_data),
    .dc_store_size (dc_store_size),
    .dc_cache_miss (dc_cache_miss),
    .dc_rdata      (dc_rdata),
    .dc_tag        (dc_tag),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
  );

  initial CLK_cpu = 1'b0;
  always #5 CLK_cpu = ~CLK_cpu;

  // Issue one request and service it until resp_valid; cycle 1 is the cycle after accept.
  task automatic run_req(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input int rd_lat, input logic [31:0] rd_data,
                         input int wb_lat);
    int memcnt;
    logic prev_ack;
    r_lat = -1; r_err = 1'b0; r_rdata = '0;
    saw_mem = 0; saw_read_en = 0; saw_write_en = 0; saw_fetch = 0;
    onehot_bad = 0; ack_hold_bad = 0; wb_seen = 0;
    r_lk_addr = '0; r_rd_addr = '0; r_wb_addr = '0;
    r_st_data = '0; r_fetch_data = '0; r_wb_data = '0; r_store_size = '0;
    memcnt = 0; prev_ack = 1'b0;
    @(negedge CLK_cpu);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    @(negedge CLK_cpu);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_ack = 1'b0;
      if (prev_ack && mem_req) ack_hold_bad = 1'b1;
      prev_ack = 1'b0;
      if (int'(dc_read_en) + int'(dc_write_en) + int'(dc_fetch) > 1) onehot_bad = 1'b1;
      if (dc_read_en) begin
        saw_read_en = 1'b1; r_lk_addr = dc_read_addr;
      end
      if (dc_write_en) begin
        saw_write_en = 1'b1; r_lk_addr = dc_write_addr;
        r_store_size = dc_store_size; r_st_data = dc_write_data;
      end
      if (dc_fetch) begin
        saw_fetch = 1'b1; r_fetch_data = dc_write_data;
        model_present = 1'b1; model_data = dc_write_data;
      end
      if (mem_req) begin
        saw_mem = 1'b1;
        memcnt++;
        if (memcnt == (mem_we ? wb_lat : rd_lat)) begin
          mem_ack = 1'b1; mem_rdata = rd_data; prev_ack = 1'b1; memcnt = 0;
          if (mem_we) begin
            wb_seen = 1'b1; r_wb_addr = mem_addr; r_wb_data = mem_wdata;
          end else begin
            r_rd_addr = mem_addr;
          end
        end
      end
      if (resp_valid) begin
        r_lat = cyc; r_err = resp_err; r_rdata = resp_rdata;
        break;
      end
      @(negedge CLK_cpu);
    end
    mem_ack = 1'b0;
    checks++;
    if (r_lat < 0) begin
      errors++;
      $display("FAIL resp_timeout got no resp_valid want one within 60 cycles");
    end
    @(negedge CLK_cpu);
  endtask

  task automatic test_reset();
    RST_cpu_n = 1'b0;
    repeat (2) @(negedge CLK_cpu);
    RST_cpu_n = 1'b1;
    @(negedge CLK_cpu);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    checks++;
    if ({resp_valid, dc_read_en, dc_write_en, dc_fetch, mem_req} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {resp_valid, dc_read_en, dc_write_en, dc_fetch, mem_req});
    end
    checks++;
    if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_hits, stat_misses);
    end
  endtask

  task automatic test_hit_load();
    model_present = 1'b1; model_data = 32'hDEADBEEF; always_miss = 1'b0;
    run_req(1'b0, 20'h00404, 32'h0, 2'b10, 1, 32'h0, 1);
    checks++;
    if (r_lat != 4) begin
      errors++; $display("FAIL hit_latency got %0d want 4", r_lat);
    end
    checks++;
    if (r_err !== 1'b0 || r_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hit_rdata got err=%b %h want err=0 deadbeef", r_err, r_rdata);
    end
    checks++;
    if (!saw_read_en || r_lk_addr !== 20'h00404 || saw_mem) begin
      errors++;
      $display("FAIL hit_cmds got rd=%b addr=%h mem=%b want 1 00404 0",
               saw_read_en, r_lk_addr, saw_mem);
    end
    checks++;
    if (stat_hits !== 16'd1 || stat_misses !== 16'd0) begin
      errors++; $display("FAIL hit_stats got %0d/%0d want 1/0", stat_hits, stat_misses);
    end
  endtask

  task automatic test_store_hit();
    model_present = 1'b1; model_data = 32'h01234567;
    run_req(1'b1, 20'h00202, 32'h0000BEEF, 2'b01, 1, 32'h0, 1);
    checks++;
    if (r_lat != 4 || r_err !== 1'b0 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_resp got lat=%0d err=%b rdata=%h want 4 0 0", r_lat, r_err, r_rdata);
    end
    checks++;
    if (!saw_write_en || saw_read_en || r_lk_addr !== 20'h00202 || r_store_size !== 2'b01 ||
        r_st_data !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL store_cmds got wr=%b rd=%b addr=%h size=%b data=%h want 1 0 00202 01 0000beef",
               saw_write_en, saw_read_en, r_lk_addr, r_store_size, r_st_data);
    end
    checks++;
    if (stat_hits !== 16'd2) begin
      errors++; $display("FAIL store_stats got %0d want 2", stat_hits);
    end
  endtask

  task automatic test_misaligned();
    run_req(1'b1, 20'h00102, 32'h55AA55AA, 2'b10, 1, 32'h0, 1);
    checks++;
    if (r_lat != 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL misalign_word got lat=%0d err=%b rdata=%h want 2 1 0", r_lat, r_err, r_rdata);
    end
    checks++;
    if (saw_read_en || saw_write_en || saw_fetch || saw_mem) begin
      errors++; $display("FAIL misalign_quiet got cache/mem activity want none");
    end
    run_req(1'b0, 20'h00000, 32'h0, 2'b11, 1, 32'h0, 1);
    checks++;
    if (r_lat != 2 || r_err !== 1'b1) begin
      errors++; $display("FAIL misalign_size11 got lat=%0d err=%b want 2 1", r_lat, r_err);
    end
    run_req(1'b0, 20'h00203, 32'h0, 2'b01, 1, 32'h0, 1);
    checks++;
    if (r_lat != 2 || r_err !== 1'b1) begin
      errors++; $display("FAIL misalign_half got lat=%0d err=%b want 2 1", r_lat, r_err);
    end
  endtask

  task automatic test_clean_miss();
    model_present = 1'b0; always_miss = 1'b0; vic_tag = 16'h0000; vic_data = 32'h0;
    run_req(1'b0, 20'h12344, 32'h0, 2'b10, 3, 32'hCAFEF00D, 1);
    checks++;
    if (r_lat != 11) begin
      errors++; $display("FAIL clean_latency got %0d want 11", r_lat);
    end
    checks++;
    if (r_err !== 1'b0 || r_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL clean_rdata got err=%b %h want 0 cafef00d", r_err, r_rdata);
    end
    checks++;
    if (r_rd_addr !== 20'h12344 || r_fetch_data !== 32'hCAFEF00D || wb_seen) begin
      errors++;
      $display("FAIL clean_fill got maddr=%h fill=%h wb=%b want 12344 cafef00d 0",
               r_rd_addr, r_fetch_data, wb_seen);
    end
    checks++;
    if (onehot_bad || ack_hold_bad) begin
      errors++; $display("FAIL clean_protocol got onehot=%b hold=%b want 0 0", onehot_bad, ack_hold_bad);
    end
    checks++;
    if (stat_hits !== 16'd2 || stat_misses !== 16'd1) begin
      errors++; $display("FAIL clean_stats got %0d/%0d want 2/1", stat_hits, stat_misses);
    end
  endtask

  task automatic test_dirty_miss();
    model_present = 1'b0; vic_tag = 16'h3055; vic_data = 32'h11223344;
    run_req(1'b0, 20'h12344, 32'h0, 2'b10, 3, 32'h55667788, 2);
    checks++;
    if (r_lat != 13 || r_rdata !== 32'h55667788 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL dirty_resp got lat=%0d err=%b rdata=%h want 13 0 55667788",
               r_lat, r_err, r_rdata);
    end
    checks++;
    if (!wb_seen || r_wb_addr !== 20'h15744 || r_wb_data !== 32'h11223344) begin
      errors++;
      $display("FAIL dirty_wb got seen=%b addr=%h data=%h want 1 15744 11223344",
               wb_seen, r_wb_addr, r_wb_data);
    end
    checks++;
    if (stat_misses !== 16'd2 || ack_hold_bad) begin
      errors++; $display("FAIL dirty_stats got misses=%0d hold=%b want 2 0", stat_misses, ack_hold_bad);
    end
  endtask

  task automatic test_replay_miss();
    always_miss = 1'b1; vic_tag = 16'h0000;
    run_req(1'b0, 20'h00800, 32'h0, 2'b10, 1, 32'h77777777, 1);
    always_miss = 1'b0;
    checks++;
    if (r_lat != 9 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
      errors++;
      $display("FAIL replay_resp got lat=%0d err=%b rdata=%h want 9 1 0", r_lat, r_err, r_rdata);
    end
    checks++;
    if (stat_misses !== 16'd3 || stat_hits !== 16'd2) begin
      errors++; $display("FAIL replay_stats got %0d/%0d want 2/3", stat_hits, stat_misses);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] resp_mask, ready_mask;
    model_present = 1'b1; model_data = 32'hA5A50001;
    resp_mask = '0; ready_mask = '0;
    @(negedge CLK_cpu);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00408; req_size = 2'b10;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge CLK_cpu);
      resp_mask[cyc]  = resp_valid;
      ready_mask[cyc] = req_ready;
    end
    req_valid = 1'b0;
    @(negedge CLK_cpu);
    checks++;
    if (resp_mask !== 10'b10_0001_0000) begin
      errors++; $display("FAIL b2b_resp got %b want 1000010000", resp_mask);
    end
    checks++;
    if (ready_mask !== 10'b00_0010_0000) begin
      errors++; $display("FAIL b2b_ready got %b want 0000100000", ready_mask);
    end
    checks++;
    if (stat_hits !== 16'd4) begin
      errors++; $display("FAIL b2b_stats got %0d want 4", stat_hits);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic seen;
    logic stray;
    model_present = 1'b0; vic_tag = 16'h0; seen = 1'b0; stray = 1'b0;
    @(negedge CLK_cpu);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00C00; req_size = 2'b10;
    @(negedge CLK_cpu);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK_cpu);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_reach got no mem_req want mem_req within 10 cycles");
    end
    RST_cpu_n = 1'b0;
    @(negedge CLK_cpu);
    RST_cpu_n = 1'b1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle got req=%b ready=%b resp=%b want 0 1 0",
               mem_req, req_ready, resp_valid);
    end
    checks++;
    if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
      errors++; $display("FAIL rstmid_stats got %0d/%0d want 0/0", stat_hits, stat_misses);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge CLK_cpu);
    mem_ack = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (req_ready !== 1'b1 || mem_req || resp_valid || dc_fetch) stray = 1'b1;
      @(negedge CLK_cpu);
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL rstmid_stale_ack got activity after stale ack want none");
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    RST_cpu_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_present = 1'b0; model_data = '0; always_miss = 1'b0;
    vic_tag = '0; vic_data = '0;
    test_reset();
    test_hit_load();
    test_store_hit();
    test_misaligned();
    test_clean_miss();
    test_dirty_miss();
    test_replay_miss();
    test_back_to_back();
    test_reset_mid_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss-handling sequencer for the 4-way, 4 KB data cache. It accepts one load/store at a time from the load/store unit, drives the cache's read, write and fetch command pins, and resolves misses by fetching the missing word from backing memory. A dirty victim is written back before the original request is replayed. The block sits between the LSU, the data cache and the memory bus arbiter, and also keeps hit and miss statistics.

## Interface
- STAT_W, 16: width of the saturating hit/miss counters.
- CLK_cpu  in  1  CPU clock; all logic is on its rising edge.
- RST_cpu_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  LSU request strobe; accepted only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  20  byte address.
- req_wdata  in  32  store data.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_ready  out  1  high in IDLE only.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; misaligned/illegal request or replay miss.
- resp_rdata  out  32  load data; 0 for stores and errors.
- dc_read_en, dc_write_en, dc_fetch  out  1  cache command; at most one high (onehot0).
- dc_read_addr, dc_write_addr  out  20  cache addresses.
- dc_write_data  out  32  store data or fill data.
- dc_store_size  out  2  cache write size.
- dc_cache_miss  in  1  cache miss flag.
- dc_rdata  in  32  cache read data / victim data.
- dc_tag  in  16  victim tag (bit 13 valid, bit 12 dirty, bits 9:0 tag).
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = writeback.
- mem_addr  out  20  word-aligned memory address.
- mem_wdata  out  32  writeback data.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  32  fill data.
- stat_hits, stat_misses  out  STAT_W  saturating counters.

## Operation
- States: IDLE, CHK, LK1, LK2, MRD, FL1, FL2, WB, RSP.
- IDLE: when req_valid is high, latch addr, we, wdata and size into req regs and go to CHK.
- CHK: the request is misaligned if size 11, or size 01 with addr[0]=1, or size 10 with addr[1:0]≠0.
  - Misaligned: go to RSP with err=1. No cache or memory access occurs.
  - Otherwise go to LK1 with replay=0.
- LK1, LK2: drive one command, stable for both cycles.
  - Load: dc_read_en=1, dc_read_addr=addr.
  - Store: dc_write_en=1, dc_write_addr=addr, dc_write_data=wdata, dc_store_size=size.
- End of LK2: sample dc_cache_miss and dc_rdata.
  - Hit: capture rdata for loads. If replay=0, increment stat_hits. Go to RSP.
  - Miss with replay=0: increment stat_misses, go to MRD.
  - Miss with replay=1: go to RSP with err=1.
- MRD: mem_req=1, mem_we=0, mem_addr={addr[19:2],2'b00}. On mem_ack, latch mem_rdata into fill reg and go to FL1.
- FL1, FL2: dc_fetch=1, dc_write_addr=addr, dc_write_data=fill.
  - End of FL2: latch dc_tag and dc_rdata as the victim.
  - If victim bit13 & bit12, go to WB. Otherwise go to LK1 with replay=1.
- WB: mem_req=1, mem_we=1, mem_addr={victim[9:0], addr[9:2], 2'b00}, mem_wdata=victim data. On mem_ack, go to LK1 with replay=1.
- RSP: resp_valid=1 for one cycle with err/rdata, then return to IDLE. rdata is 0 when err or store.
- Counters saturate at all-ones; they never wrap.
- Default for every dc_*/mem_* output is 0 when not driven by the current state.

## Timing
- Reset, in any state including mid-miss: state=IDLE and all outputs 0, except req_ready=1 after reset. Counters, replay, fill and victim regs are cleared.
  - An outstanding mem_req is dropped. A late mem_ack arriving in IDLE is ignored.
- Latency from accept (req_valid & req_ready edge) to resp_valid:
  - Hit: 4 cycles (CHK, LK1, LK2, RSP).
  - Misaligned: 2 cycles.
  - Clean miss: 8 + N cycles, where N = cycles mem_req is high up to and including the mem_ack cycle.
  - Dirty miss: adds WB cycles.
- req_valid is ignored outside IDLE. A request presented in the same cycle as RSP is not accepted.
- mem_addr, mem_we and mem_wdata are stable while mem_req is high. mem_req deasserts on the cycle after mem_ack.
- Stores complete with resp_rdata=0.

## Test plan
- Hit load: a preloaded cache returns dc_cache_miss=0, dc_rdata=0xDEADBEEF on load 0x00404 -> resp_valid 4 cycles after accept, rdata 0xDEADBEEF, stat_hits=1, mem_req never high.
- Misaligned: store size 10, addr 0x00102 -> resp_err=1 at cycle 2; dc_* and mem_req stay 0.
- Clean miss load 0x12344, mem_ack after 3 cycles with 0xCAFEF00D, victim tag 0x0000 -> MRD, FL1/FL2 with dc_write_data 0xCAFEF00D, replay hit, rdata 0xCAFEF00D, stat_misses=1.
- Dirty miss: victim tag 0x3055 (valid, dirty, tag 0x055) with data 0x11223344, addr 0x12344 -> WB with mem_addr 0x15744, mem_wdata 0x11223344, then replay.
- Replay miss: cache model reports a miss on both lookups -> resp_err=1 after one fill; stat_misses increments only once.
- Reset asserted during MRD -> next cycle IDLE, mem_req=0, req_ready=1, counters 0; a stale mem_ack is ignored.
